// File: rtl/packet_fifo.sv
// Frame-aware synchronous FIFO: frames are committed on a good end-of-packet and are rewound on drop or overflow.
// Optional drop/overflow statistics counters are enabled by defining PACKET_FIFO_STATS_EN.
module packet_fifo #(
  parameter int DWIDTH             = 8,
  parameter int AWIDTH             = 3,
  parameter int ALMOST_FULL_VALUE  = 6,
  parameter int ALMOST_EMPTY_VALUE = 2
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              eop_i,
  input  logic              drop_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              eop_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic [AWIDTH:0]   pkt_cnt_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic [15:0]       drop_cnt_o,
  output logic [15:0]       ovf_cnt_o
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_LVL  = (AWIDTH + 1)'(ALMOST_FULL_VALUE);
  localparam logic [AWIDTH:0] AE_LVL  = (AWIDTH + 1)'(ALMOST_EMPTY_VALUE);
  localparam logic [AWIDTH:0] PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_FRAME,
    WR_DISCARD
  } wr_state_e;

  wr_state_e state_q, state_d;

  logic [DWIDTH:0] mem [DEPTH];
  logic [AWIDTH:0] wr_ptr, wr_commit, rd_ptr, pkt_cnt;
  logic [AWIDTH:0] total_occ, used_occ;
  logic            full, empty, rd_accept, head_eop;
  logic            write_en, commit, rewind, ovf_evt, overflow_q;

  assign total_occ = wr_ptr - rd_ptr;
  assign used_occ  = wr_commit - rd_ptr;
  assign full      = (total_occ == DEPTH_W);
  assign empty     = (used_occ == '0);
  assign head_eop  = mem[rd_ptr[AWIDTH-1:0]][DWIDTH];
  assign rd_accept = rdreq_i && !empty;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state_q <= WR_IDLE;
    else          state_q <= state_d;
  end

  // Write-side frame control; a rewind returns wr_ptr to the last committed boundary.
  always_comb begin
    state_d  = state_q;
    write_en = 1'b0;
    commit   = 1'b0;
    rewind   = 1'b0;
    ovf_evt  = 1'b0;
    case (state_q)
      WR_IDLE, WR_FRAME: begin
        if (wrreq_i) begin
          if (!full) begin
            if (!eop_i) begin
              write_en = 1'b1;
              state_d  = WR_FRAME;
            end else if (!drop_i) begin
              write_en = 1'b1;
              commit   = 1'b1;
              state_d  = WR_IDLE;
            end else begin
              rewind  = 1'b1;
              state_d = WR_IDLE;
            end
          end else if (!eop_i) begin
            state_d = WR_DISCARD;
          end else begin
            rewind  = 1'b1;
            ovf_evt = 1'b1;
            state_d = WR_IDLE;
          end
        end
      end
      WR_DISCARD: begin
        if (wrreq_i && eop_i) begin
          rewind  = 1'b1;
          ovf_evt = 1'b1;
          state_d = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (write_en) mem[wr_ptr[AWIDTH-1:0]] <= {eop_i, data_i};
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr     <= '0;
      wr_commit  <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (rewind)        wr_ptr <= wr_commit;
      else if (write_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (commit)    wr_commit <= wr_ptr + PTR_ONE;
      if (rd_accept) rd_ptr    <= rd_ptr + PTR_ONE;
      // A commit and an eop read in the same cycle cancel out.
      case ({commit, rd_accept && head_eop})
        2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
        2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
      overflow_q <= ovf_evt;
    end
  end

  assign {eop_o, q_o}   = empty ? '0 : mem[rd_ptr[AWIDTH-1:0]];
  assign empty_o        = empty;
  assign full_o         = full;
  assign usedw_o        = used_occ;
  assign pkt_cnt_o      = pkt_cnt;
  assign almost_full_o  = (total_occ >= AF_LVL);
  assign almost_empty_o = (used_occ < AE_LVL);
  assign overflow_o     = overflow_q;

`ifdef PACKET_FIFO_STATS_EN
  logic        drop_evt;
  logic [15:0] drop_cnt, ovf_cnt;

  // Every rewind is either a requested drop or an overflow discard.
  assign drop_evt = rewind && !ovf_evt;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (drop_evt && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      if (ovf_evt && (ovf_cnt != 16'hFFFF))   ovf_cnt  <= ovf_cnt + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt;
  assign ovf_cnt_o  = ovf_cnt;
`else
  assign drop_cnt_o = '0;
  assign ovf_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_packet_fifo.sv
// Scoreboard bench for packet_fifo: a queue-based frame model predicts status, and a monitor checks each read beat.
module tb_packet_fifo;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFV   = 6;
  localparam int AEV   = 2;

  logic          clk_i = 1'b0;
  logic          arstn_i;
  logic [DW-1:0] data_i;
  logic          wrreq_i, eop_i, drop_i, rdreq_i;
  logic [DW-1:0] q_o;
  logic          eop_o, empty_o, full_o, almost_full_o, almost_empty_o, overflow_o;
  logic [AW:0]   usedw_o, pkt_cnt_o;
  logic [15:0]   drop_cnt_o, ovf_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model: committed beats, the open frame, and the scoreboard of expected read beats.
  logic [DW:0] mdl_q[$];
  logic [DW:0] pend_q[$];
  logic [DW:0] exp_q[$];
  int          m_pkts, m_dropcnt, m_ovfcnt;
  bit          m_discard, m_ovf;

  packet_fifo #(
    .DWIDTH(DW), .AWIDTH(AW), .ALMOST_FULL_VALUE(AFV), .ALMOST_EMPTY_VALUE(AEV)
  ) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .data_i(data_i), .wrreq_i(wrreq_i),
    .eop_i(eop_i), .drop_i(drop_i), .rdreq_i(rdreq_i), .q_o(q_o), .eop_o(eop_o),
    .empty_o(empty_o), .full_o(full_o), .usedw_o(usedw_o), .pkt_cnt_o(pkt_cnt_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .ovf_cnt_o(ovf_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, actual, expected);
    end
  endtask

  task automatic modelReset();
    mdl_q.delete();
    pend_q.delete();
    exp_q.delete();
    m_pkts    = 0;
    m_dropcnt = 0;
    m_ovfcnt  = 0;
    m_discard = 0;
    m_ovf     = 0;
  endtask

  // One clock of frame semantics, using occupancy as seen before the edge.
  task automatic modelStep(input bit wr, input bit eop, input bit drop, input logic [DW-1:0] d, input bit rd);
    bit          full_now;
    logic [DW:0] head;
    full_now = (mdl_q.size() + pend_q.size()) == DEPTH;
    m_ovf    = 0;
    if (rd && mdl_q.size() > 0) begin
      head = mdl_q.pop_front();
      if (head[DW]) m_pkts--;
    end
    if (wr) begin
      if (m_discard) begin
        if (eop) begin
          pend_q.delete();
          m_discard = 0;
          m_ovf     = 1;
          m_ovfcnt++;
        end
      end else if (!full_now) begin
        if (!eop) pend_q.push_back({1'b0, d});
        else if (!drop) begin
          pend_q.push_back({1'b1, d});
          foreach (pend_q[i]) begin
            mdl_q.push_back(pend_q[i]);
            exp_q.push_back(pend_q[i]);
          end
          pend_q.delete();
          m_pkts++;
        end else begin
          pend_q.delete();
          m_dropcnt++;
        end
      end else if (!eop) begin
        m_discard = 1;
      end else begin
        pend_q.delete();
        m_ovf = 1;
        m_ovfcnt++;
      end
    end
  endtask

  task automatic checkOutput();
    int used, tot;
    used = mdl_q.size();
    tot  = used + pend_q.size();
    checkValue("empty", empty_o, used == 0);
    checkValue("full", full_o, tot == DEPTH);
    checkValue("usedw", usedw_o, used);
    checkValue("pkt_cnt", pkt_cnt_o, m_pkts);
    checkValue("almost_full", almost_full_o, tot >= AFV);
    checkValue("almost_empty", almost_empty_o, used < AEV);
    checkValue("overflow", overflow_o, m_ovf);
`ifdef PACKET_FIFO_STATS_EN
    checkValue("drop_cnt", drop_cnt_o, m_dropcnt);
    checkValue("ovf_cnt", ovf_cnt_o, m_ovfcnt);
`else
    checkValue("drop_cnt", drop_cnt_o, 0);
    checkValue("ovf_cnt", ovf_cnt_o, 0);
`endif
  endtask

  task automatic checkResetValues();
    checkValue("rst_empty", empty_o, 1);
    checkValue("rst_full", full_o, 0);
    checkValue("rst_usedw", usedw_o, 0);
    checkValue("rst_pkt_cnt", pkt_cnt_o, 0);
    checkValue("rst_almost_full", almost_full_o, 0);
    checkValue("rst_almost_empty", almost_empty_o, 1);
    checkValue("rst_overflow", overflow_o, 0);
    checkValue("rst_q", q_o, 0);
    checkValue("rst_eop", eop_o, 0);
    checkValue("rst_drop_cnt", drop_cnt_o, 0);
    checkValue("rst_ovf_cnt", ovf_cnt_o, 0);
  endtask

  task automatic applyStimulus(input bit wr, input bit eop, input bit drop, input logic [DW-1:0] d, input bit rd);
    @(negedge clk_i);
    checkOutput();
    wrreq_i = wr;
    eop_i   = eop;
    drop_i  = drop;
    data_i  = d;
    rdreq_i = rd;
    modelStep(wr, eop, drop, d, rd);
  endtask

  task automatic idleCycles(input int n, input bit rd);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, rd);
  endtask

  task automatic writeFrame(input int len, input logic [DW-1:0] base, input bit drop);
    for (int i = 0; i < len; i++)
      applyStimulus(1, i == len - 1, drop && (i == len - 1), base + DW'(i), 0);
  endtask

  task automatic asyncReset();
    @(negedge clk_i);
    checkOutput();
    wrreq_i = 0; eop_i = 0; drop_i = 0; rdreq_i = 0; data_i = '0;
    #2 arstn_i = 1'b0;
    #1 checkResetValues();
    modelReset();
    @(negedge clk_i);
    arstn_i = 1'b1;
  endtask

  // Monitor: every accepted read must present the next beat the scoreboard expects.
  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge clk_i);
      #1;
      if (arstn_i && rdreq_i && !empty_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL read_beat at %0t: got eop=%0b q=%h, want no beat", $time, eop_o, q_o);
        end else begin
          e = exp_q.pop_front();
          if ({eop_o, q_o} !== e) begin
            errors++;
            $display("[TB] FAIL read_beat at %0t: got eop=%0b q=%h, want eop=%0b q=%h",
                     $time, eop_o, q_o, e[DW], e[DW-1:0]);
          end
        end
      end
    end
  end

  initial begin
    arstn_i = 1'b0;
    wrreq_i = 0; eop_i = 0; drop_i = 0; rdreq_i = 0; data_i = '0;
    modelReset();
    repeat (2) @(negedge clk_i);
    checkResetValues();
    arstn_i = 1'b1;

    $display("[TB] three-beat frame then read back");
    writeFrame(3, 8'hA1, 0);
    idleCycles(1, 0);
    checkValue("frameA_usedw", usedw_o, 3);
    checkValue("frameA_head", q_o, 8'hA1);
    idleCycles(3, 1);
    idleCycles(2, 0);

    $display("[TB] dropped frame followed by good frame");
    writeFrame(2, 8'hC0, 1);
    writeFrame(1, 8'hB0, 0);
    idleCycles(1, 0);
    checkValue("drop_usedw", usedw_o, 1);
    checkValue("drop_head", q_o, 8'hB0);
    idleCycles(3, 1);

    $display("[TB] overflow with committed frame resident");
    writeFrame(5, 8'hD0, 0);
    writeFrame(4, 8'hE0, 0);
    idleCycles(2, 0);
    checkValue("ovf_usedw", usedw_o, 5);
    idleCycles(8, 1);

    $display("[TB] oversized frame into empty fifo");
    writeFrame(12, 8'h10, 0);
    writeFrame(2, 8'h40, 0);
    idleCycles(1, 0);
    checkValue("long_usedw", usedw_o, 2);
    idleCycles(4, 1);

    $display("[TB] back-to-back single-beat frames with continuous reads");
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, DW'(8'h60 + i), 1);
    idleCycles(3, 1);

    $display("[TB] asynchronous reset mid-frame");
    writeFrame(1, 8'h70, 0);
    applyStimulus(1, 0, 0, 8'h71, 0);
    applyStimulus(1, 0, 0, 8'h72, 0);
    asyncReset();
    writeFrame(2, 8'h80, 0);
    idleCycles(3, 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      bit wr, eop, drop, rd;
      wr   = $urandom_range(0, 99) < 60;
      eop  = wr && ($urandom_range(0, 99) < 25);
      drop = eop && ($urandom_range(0, 99) < 15);
      rd   = $urandom_range(0, 99) < ((i < 1500) ? 45 : 20);
      applyStimulus(wr, eop, drop, DW'($urandom), rd);
    end
    idleCycles(12, 1);
    @(negedge clk_i);
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
